// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and default parameter constants for the register-file
// write arbiter (rf_wr_arbiter) and its MDU pending-write queue (rf_wr_fifo).
package rf_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 5;
  localparam int unsigned DEF_D_WIDTH      = 32;
  localparam int unsigned DEF_FIFO_DEPTH   = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // Queue entry at default widths; the top re-declares the same layout at its
  // own parameter widths and hands it to the queue as a type parameter.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] rd;
    logic [DEF_D_WIDTH-1:0]    wdata;
  } rf_wr_entry_t;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if: bundle of writeback, MDU, register-file and pending-check
// signals around rf_wr_arbiter.
//   master : pipeline side (drives wb_*, mdu_valid/rd/wdata, chk_*)
//   slave  : arbiter side  (drives mdu_ready, rf_*, wb_stall, pend_*)
interface rf_wr_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned D_WIDTH    = DEF_D_WIDTH
);
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [D_WIDTH-1:0]    wb_wdata;
  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [ADDR_WIDTH-1:0] mdu_rd;
  logic [D_WIDTH-1:0]    mdu_wdata;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [D_WIDTH-1:0]    rf_wdata;
  logic                  wb_stall;
  logic [ADDR_WIDTH-1:0] chk_rs;
  logic [ADDR_WIDTH-1:0] chk_rt;
  logic                  pend_rs;
  logic                  pend_rt;

  modport master (
    output wb_we, wb_rd, wb_wdata, mdu_valid, mdu_rd, mdu_wdata, chk_rs, chk_rt,
    input  mdu_ready, rf_we, rf_rd, rf_wdata, wb_stall, pend_rs, pend_rt
  );

  modport slave (
    input  wb_we, wb_rd, wb_wdata, mdu_valid, mdu_rd, mdu_wdata, chk_rs, chk_rt,
    output mdu_ready, rf_we, rf_rd, rf_wdata, wb_stall, pend_rs, pend_rt
  );
endinterface

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: FIFO of pending MDU register writes.
// Ports: clk, rst (sync, active-high); push_i/push_data_i enqueue;
//        pop_i dequeue; head_o oldest entry; empty_o / full_o from the
//        registered count. With RF_WR_ARBITER_PEND_CHECK_EN defined, ents_o /
//        vld_o expose every slot and its valid bit for the pending check.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_FIFO_DEPTH,
  parameter type         entry_t = rf_wr_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o,
  output logic   full_o
`ifdef RF_WR_ARBITER_PEND_CHECK_EN
  ,
  output entry_t [DEPTH-1:0] ents_o,
  output logic   [DEPTH-1:0] vld_o
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

`ifdef RF_WR_ARBITER_PEND_CHECK_EN
  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off       = PW'(i) - rd_ptr_q;
      ents_o[i] = mem_q[i];
      vld_o[i]  = ({1'b0, off} < cnt_q);
    end
  end
`endif

endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: merges writeback-stage writes and queued multi-cycle-unit
// (MDU) results onto one registered register-file write port. Writeback always
// wins; MDU results wait in rf_wr_fifo and drain on idle writeback cycles. A
// starve counter raises wb_stall to ask the pipeline for a bubble.
// Ports: clk, rst (sync, active-high); bus (rf_wr_arbiter_if.slave) carrying
//        wb_*, mdu_*, rf_*, wb_stall, chk_* and pend_*.
// Option: RF_WR_ARBITER_PEND_CHECK_EN builds the pend_rs/pend_rt comparators
//         (otherwise both are tied low).
module rf_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned D_WIDTH      = DEF_D_WIDTH,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic             clk,
  input logic             rst,
  rf_wr_arbiter_if.slave  bus
);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [D_WIDTH-1:0]    wdata;
  } entry_t;

  logic                  wb_eff;
  logic                  push;
  logic                  pop;
  logic                  q_empty;
  logic                  q_full;
  entry_t                q_head;
  entry_t                push_data;

  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_rd_q;
  logic [D_WIDTH-1:0]    rf_wdata_q;
  logic [SW-1:0]         starve_q;
  logic [SW-1:0]         starve_d;
  logic                  stall_q;

`ifdef RF_WR_ARBITER_PEND_CHECK_EN
  entry_t [FIFO_DEPTH-1:0] q_ents;
  logic   [FIFO_DEPTH-1:0] q_vld;
  logic                    rf_mdu_q;
  logic                    pend_rs;
  logic                    pend_rt;
`endif

  rf_wr_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (q_head),
    .empty_o     (q_empty),
    .full_o      (q_full)
`ifdef RF_WR_ARBITER_PEND_CHECK_EN
    ,
    .ents_o      (q_ents),
    .vld_o       (q_vld)
`endif
  );

  always_comb begin
    wb_eff          = bus.wb_we && (bus.wb_rd != '0);
    // rd==0 MDU results complete the handshake but are never queued.
    push            = bus.mdu_valid && !q_full && (bus.mdu_rd != '0);
    pop             = !wb_eff && !q_empty;
    push_data.rd    = bus.mdu_rd;
    push_data.wdata = bus.mdu_wdata;

    starve_d = starve_q;
    if (pop || q_empty)
      starve_d = '0;
    else if (wb_eff && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= (starve_d == SW'(STARVE_LIMIT));
      if (wb_eff) begin
        rf_we_q    <= 1'b1;
        rf_rd_q    <= bus.wb_rd;
        rf_wdata_q <= bus.wb_wdata;
      end else if (pop) begin
        rf_we_q    <= 1'b1;
        rf_rd_q    <= q_head.rd;
        rf_wdata_q <= q_head.wdata;
      end else begin
        rf_we_q    <= 1'b0;
      end
    end
  end

  assign bus.mdu_ready = !q_full;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.wb_stall  = stall_q;

`ifdef RF_WR_ARBITER_PEND_CHECK_EN
  // Tracks whether the write on the rf port was drained from the queue.
  always_ff @(posedge clk) begin
    if (rst) rf_mdu_q <= 1'b0;
    else     rf_mdu_q <= pop;
  end

  always_comb begin
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (q_vld[i] && (q_ents[i].rd == bus.chk_rs)) pend_rs = 1'b1;
      if (q_vld[i] && (q_ents[i].rd == bus.chk_rt)) pend_rt = 1'b1;
    end
    if (rf_we_q && rf_mdu_q && (rf_rd_q == bus.chk_rs)) pend_rs = 1'b1;
    if (rf_we_q && rf_mdu_q && (rf_rd_q == bus.chk_rt)) pend_rt = 1'b1;
    if (bus.chk_rs == '0) pend_rs = 1'b0;
    if (bus.chk_rt == '0) pend_rt = 1'b0;
  end

  assign bus.pend_rs = pend_rs;
  assign bus.pend_rt = pend_rt;
`else
  assign bus.pend_rs = 1'b0;
  assign bus.pend_rt = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  typedef struct {
    int unsigned rd;
    int unsigned data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wr_arbiter_if #(.ADDR_WIDTH(AW), .D_WIDTH(DW)) bus ();

  rf_wr_arbiter #(
    .ADDR_WIDTH   (AW),
    .D_WIDTH      (DW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  wr_t         q[$];
  int unsigned starve;
  bit          m_we;
  int unsigned m_rd;
  int unsigned m_data;
  bit          m_from_mdu;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  string       phase;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic bit pend_model(input int unsigned a);
    bit hit = 0;
`ifdef RF_WR_ARBITER_PEND_CHECK_EN
    if (a != 0) begin
      foreach (q[i]) if (q[i].rd == a) hit = 1;
      if (m_we && m_from_mdu && m_rd == a) hit = 1;
    end
`endif
    return hit;
  endfunction

  task automatic drive(input bit we, input int unsigned wrd, input int unsigned wd,
                       input bit mv, input int unsigned mrd, input int unsigned md);
    bus.wb_we     = we;
    bus.wb_rd     = AW'(wrd);
    bus.wb_wdata  = DW'(wd);
    bus.mdu_valid = mv;
    bus.mdu_rd    = AW'(mrd);
    bus.mdu_wdata = DW'(md);
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare every observable output just after the edge.
  task automatic cycle();
    bit wb, acc, was_empty, popped;
    wr_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      starve = 0; m_we = 0; m_rd = 0; m_data = 0; m_from_mdu = 0;
    end else begin
      wb        = bus.wb_we && (bus.wb_rd != 0);
      acc       = bus.mdu_valid && (q.size() < DEPTH);
      was_empty = (q.size() == 0);
      popped    = 0;
      if (wb) begin
        m_we = 1; m_rd = bus.wb_rd; m_data = bus.wb_wdata; m_from_mdu = 0;
      end else if (!was_empty) begin
        e = q.pop_front();
        m_we = 1; m_rd = e.rd; m_data = e.data; m_from_mdu = 1; popped = 1;
      end else begin
        m_we = 0; m_from_mdu = 0;
      end
      if (acc && bus.mdu_rd != 0) begin
        e.rd = bus.mdu_rd; e.data = bus.mdu_wdata;
        q.push_back(e);
      end
      if (popped || was_empty) starve = 0;
      else if (starve < LIMIT) starve++;
    end
    #1;
    chk("rf_we", bus.rf_we, m_we);
    if (m_we || rst) begin
      chk("rf_rd", bus.rf_rd, m_rd);
      chk("rf_wdata", bus.rf_wdata, m_data);
    end
    chk("wb_stall", bus.wb_stall, starve == LIMIT);
    chk("mdu_ready", bus.mdu_ready, q.size() < DEPTH);
    chk("pend_rs", bus.pend_rs, pend_model(bus.chk_rs));
    chk("pend_rt", bus.pend_rt, pend_model(bus.chk_rt));
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    bus.chk_rs = '0;
    bus.chk_rt = '0;
    starve = 0; m_we = 0; m_rd = 0; m_data = 0; m_from_mdu = 0;

    // Reset held two cycles with an MDU result offered
    phase = "reset";
    drive(0, 0, 0, 1, 9, 32'h99);
    cycle(); cycle();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // Writeback only, then rd==0 treated as idle
    phase = "wb_only";
    drive(1, 3, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    chk("wb_rd3", bus.rf_rd, 3);
    chk("wb_data", bus.rf_wdata, 32'hDEADBEEF);
    drive(1, 0, 32'h12345678, 0, 0, 0);
    cycle();
    chk("wb_rd0_idle", bus.rf_we, 0);

    // MDU enqueue under continuous writeback, fill, then drain in order
    phase = "mdu_busy";
    drive(1, 1, 32'hA1, 1, 5, 32'h11); cycle();
    drive(1, 2, 32'hA2, 1, 6, 32'h22); cycle();
    drive(1, 4, 32'hA3, 1, 8, 32'h33); cycle();
    chk("full_ready", bus.mdu_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("drain1_rd", bus.rf_rd, 5);
    chk("drain1_data", bus.rf_wdata, 32'h11);
    cycle();
    chk("drain2_rd", bus.rf_rd, 6);
    chk("drain2_data", bus.rf_wdata, 32'h22);
    cycle();

    // Starvation: one entry held back by writeback every cycle
    phase = "starve";
    do_reset();
    drive(1, 10, 32'hB0, 1, 12, 32'hC0); cycle();
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1, 11 + i, 32'hB1 + i, 0, 0, 0);
      cycle();
    end
    chk("stall_set", bus.wb_stall, 1);
    drive(1, 20, 32'hB9, 0, 0, 0); cycle();
    chk("stall_wb_wins", bus.rf_rd, 20);
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("starved_rd", bus.rf_rd, 12);
    cycle();
    chk("stall_clear", bus.wb_stall, 0);

    // Pending check on a queued rd=7
    phase = "pend";
    bus.chk_rs = AW'(7);
    bus.chk_rt = '0;
    drive(1, 3, 32'h1, 1, 7, 32'h77); cycle();
    drive(1, 4, 32'h2, 0, 0, 0);     cycle();
    drive(0, 0, 0, 0, 0, 0);         cycle();
    cycle();
    chk("pend_done", bus.pend_rs, 0);

    // Reset with the queue full: nothing may leak to the rf port
    phase = "mid_reset";
    drive(1, 1, 32'h5, 1, 13, 32'hD1); cycle();
    drive(1, 2, 32'h6, 1, 14, 32'hD2); cycle();
    chk("full_before_rst", bus.mdu_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    chk("ready_after_rst", bus.mdu_ready, 1);
    for (int unsigned i = 0; i < 3; i++) cycle();

    // Randomized traffic
    phase = "random";
    for (int unsigned i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 7), $urandom(),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom());
      bus.chk_rs = AW'($urandom_range(0, 7));
      bus.chk_rt = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) rst = 1;
      cycle();
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-address width.
REQ-002 Parameter D_WIDTH, default 32, write-data width.
REQ-003 Parameter FIFO_DEPTH, default 2, MDU pending-write queue entries (power of two, >=2).
REQ-004 Parameter STARVE_LIMIT, default 4, consecutive blocked cycles before wb_stall asserts.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wb_we  in  1  writeback-stage write request; never back-pressured.
REQ-008 wb_rd  in  ADDR_WIDTH  writeback destination.
REQ-009 wb_wdata  in  D_WIDTH  writeback data.
REQ-010 mdu_valid  in  1  multi-cycle unit result valid.
REQ-011 mdu_ready  out  1  queue can accept; high iff queue not full.
REQ-012 mdu_rd  in  ADDR_WIDTH  MDU destination.
REQ-013 mdu_wdata  in  D_WIDTH  MDU data.
REQ-014 rf_we, rf_rd, rf_wdata  out  1/ADDR_WIDTH/D_WIDTH  registered register-file write port.
REQ-015 wb_stall  out  1  registered request to the pipeline to bubble writeback.
REQ-016 chk_rs, chk_rt  in  ADDR_WIDTH  read addresses for pending-write check.
REQ-017 pend_rs, pend_rt  out  1  a queued or in-flight MDU write targets chk_rs / chk_rt.

Function
REQ-018 Effective WB write = wb_we && wb_rd != 0; wb_rd == 0 SHALL be treated as idle.
REQ-019 MDU transfer SHALL occur when mdu_valid && mdu_ready; mdu_rd == 0 transfers SHALL be accepted and discarded.
REQ-020 Effective WB write at cycle t SHALL appear on rf_we/rf_rd/rf_wdata after edge t+1 (latency 1).
REQ-021 When WB is idle and the queue is non-empty, the queue head SHALL be dequeued to the rf port with latency 1; otherwise rf_we SHALL be 0.
REQ-022 The queue SHALL be FIFO-ordered; minimum MDU-to-rf latency is 2 edges (enqueue, then dequeue).
REQ-023 Enqueue and dequeue in the same cycle SHALL both take effect; count unchanged.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; mdu_ready SHALL be combinational from registered count only.
REQ-025 Starve counter increments each cycle the queue is non-empty and WB wins; clears on any dequeue or when the queue is empty; saturates at STARVE_LIMIT.
REQ-026 wb_stall SHALL be 1 from the edge the counter reaches STARVE_LIMIT until the edge after the next dequeue.
REQ-027 An effective WB write while wb_stall=1 SHALL still win; no data is lost.

Reset
REQ-028 With rst=1 at an edge: queue emptied, counter 0, rf_we=0, rf_rd=0, rf_wdata=0, wb_stall=0, mdu_ready=1 after that edge.
REQ-029 Reset mid-operation SHALL discard all queued MDU writes; none reach the rf port.

Configuration
REQ-030 Macro RF_WR_ARBITER_PEND_CHECK_EN defined: pend_rs/pend_rt SHALL compare chk_rs/chk_rt (nonzero) combinationally against all valid queue entries and the rf output stage when rf_we=1 and that write came from the MDU.
REQ-031 Macro undefined: pend_rs/pend_rt SHALL be tied 0 and no comparators built.

Structure
REQ-032 Shared package rf_arb_pkg SHALL hold the queue-entry typedef (rd, wdata) and default parameter constants.
REQ-033 The queue SHALL be a sub-module rf_wr_fifo; arbitration, starve counter and pending check stay in the top.

Verification
REQ-034 Reset: assert rst 2 cycles with mdu_valid=1 -> rf_we=0, wb_stall=0, mdu_ready=1, nothing written after release.
REQ-035 WB only: wb_we=1, wb_rd=3, wb_wdata=0xDEADBEEF -> next cycle rf_we=1, rf_rd=3, rf_wdata=0xDEADBEEF; wb_rd=0 -> rf_we=0.
REQ-036 MDU while WB busy: enqueue rd=5/0x11, rd=6/0x22 under continuous WB writes -> mdu_ready=0 when full; WB drops -> writes 5 then 6 on consecutive cycles.
REQ-037 Starvation: queue holds 1 entry, WB writes every cycle -> wb_stall=1 after 4 blocked cycles; WB idles 1 cycle -> entry written, wb_stall=0 next cycle.
REQ-038 Pending check (macro defined): queue holds rd=7, chk_rs=7, chk_rt=0 -> pend_rs=1, pend_rt=0; after dequeue and write completion -> pend_rs=0.
REQ-039 Reset mid-operation: queue full, assert rst -> no MDU write appears on the rf port, mdu_ready=1 after the reset edge.
